// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, rcon constants, key type, S-box table.
package aes_pkg;

  localparam int unsigned AES_NR        = 10;
  localparam logic [7:0]  AES_RCON_INIT = 8'h01;
  localparam logic [7:0]  AES_RCON_POLY = 8'h1b;

  typedef logic [127:0] key128_t;

  // Coarse view of the round counter used by the key-prep control.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_EXPAND,
    PH_DONE,
    PH_BAD
  } kp_phase_e;

  // Forward S-box, byte x at bits [8*x +: 8].
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_dkey_prep_ks_round.sv
// Combinational forward AES-128 key-schedule round (mirror of the inverse
// key step) plus the S-box lookup it uses.

module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Table lookup; synthesises to a 256x8 ROM / LUT tree.
  always_comb begin
    y = SBOX_TBL[{a, 3'b000} +: 8];
  end

endmodule

module ks_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o,
  output logic [7:0]   rcon_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign rot = {w3[23:0], w3[31:24]};

  sbox u_sb0 (.a(rot[31:24]), .y(sub[31:24]));
  sbox u_sb1 (.a(rot[23:16]), .y(sub[23:16]));
  sbox u_sb2 (.a(rot[15:8]),  .y(sub[15:8]));
  sbox u_sb3 (.a(rot[7:0]),   .y(sub[7:0]));

  // Word chain: each new word folds in the previous new word.
  always_comb begin
    n0     = w0 ^ sub ^ {rcon_i, 24'h000000};
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
    key_o  = {n0, n1, n2, n3};
    rcon_o = xtime(rcon_i);
  end

endmodule

// File: rtl/aes_dkey_prep.sv
// Iterative AES-128 forward key expansion producing the round-10 key for the
// decryption core. Optional macro AES_DKEY_CACHE_EN adds a one-entry cache
// of the last completed cipher key.

module aes_dkey_prep
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         key_v_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         dkey_v_o,
  output logic [127:0] dkey_o
);

  localparam logic [3:0] CNT_DONE = 4'(AES_NR);

  logic [3:0] cnt_q, cnt_d;
  key128_t    key_q, key_d;
  logic [7:0] rcon_q, rcon_d;

  kp_phase_e  phase;
  logic       accept;
  logic       hit;

  key128_t    rnd_in, rnd_out;
  logic [7:0] rnd_rcon_in, rnd_rcon_out;

`ifdef AES_DKEY_CACHE_EN
  key128_t    tag_q, tag_d;
  logic       tag_v_q, tag_v_d;
`endif

  // Accept and expand never coincide, so a single round datapath is shared.
  ks_round u_round (
    .key_i  (rnd_in),
    .rcon_i (rnd_rcon_in),
    .key_o  (rnd_out),
    .rcon_o (rnd_rcon_out)
  );

  // Phase decode, outputs and round-datapath input selection.
  always_comb begin
    if (cnt_q == 4'd0)          phase = PH_IDLE;
    else if (cnt_q < CNT_DONE)  phase = PH_EXPAND;
    else if (cnt_q == CNT_DONE) phase = PH_DONE;
    else                        phase = PH_BAD;

    busy_o   = (phase == PH_EXPAND);
    dkey_v_o = (phase == PH_DONE);
    dkey_o   = key_q;
    accept   = key_v_i && ((phase == PH_IDLE) || (phase == PH_DONE));

`ifdef AES_DKEY_CACHE_EN
    hit = tag_v_q && (key_i == tag_q);
`else
    hit = 1'b0;
`endif

    rnd_in      = accept ? key_i : key_q;
    rnd_rcon_in = accept ? AES_RCON_INIT : rcon_q;
  end

  // Next-state logic for counter, key and rcon (plus cache tag).
  always_comb begin
    cnt_d  = cnt_q;
    key_d  = key_q;
    rcon_d = rcon_q;
`ifdef AES_DKEY_CACHE_EN
    tag_d   = tag_q;
    tag_v_d = tag_v_q;
`endif

    case (phase)
      PH_EXPAND: begin
        cnt_d  = cnt_q + 4'd1;
        key_d  = rnd_out;
        rcon_d = rnd_rcon_out;
`ifdef AES_DKEY_CACHE_EN
        // Tag is captured at accept; it only becomes valid on completion.
        if (cnt_q == CNT_DONE - 4'd1) tag_v_d = 1'b1;
`endif
      end
      PH_IDLE, PH_DONE: begin
        cnt_d = 4'd0;
        if (accept) begin
          if (hit) begin
            cnt_d = CNT_DONE;
          end else begin
            cnt_d  = 4'd1;
            key_d  = rnd_out;
            rcon_d = rnd_rcon_out;
`ifdef AES_DKEY_CACHE_EN
            tag_d   = key_i;
            tag_v_d = 1'b0;
`endif
          end
        end
      end
      default: begin
        cnt_d = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      key_q  <= '0;
      rcon_q <= AES_RCON_INIT;
`ifdef AES_DKEY_CACHE_EN
      tag_q   <= '0;
      tag_v_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      key_q  <= key_d;
      rcon_q <= rcon_d;
`ifdef AES_DKEY_CACHE_EN
      tag_q   <= tag_d;
      tag_v_q <= tag_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_dkey_prep.sv
// Directed self-checking bench for aes_dkey_prep using FIPS-197 key vectors.
module tb_aes_dkey_prep;

  logic         clk;
  logic         reset;
  logic         key_v_i;
  logic [127:0] key_i;
  logic         busy_o;
  logic         dkey_v_o;
  logic [127:0] dkey_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [127:0] KA    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1_A = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] DK_A  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] DK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_dkey_prep dut (
    .clk      (clk),
    .reset    (reset),
    .key_v_i  (key_v_i),
    .key_i    (key_i),
    .busy_o   (busy_o),
    .dkey_v_o (dkey_v_o),
    .dkey_o   (dkey_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse a request for one cycle; returns in cycle T+1.
  task automatic request(input logic [127:0] k);
    key_v_i = 1'b1;
    key_i   = k;
    tick;
    key_v_i = 1'b0;
  endtask

  // From T+1: full 10-cycle expansion, checks through T+11.
  task automatic expect_full(input string tag, input logic [127:0] rk1, input logic [127:0] dk);
    chk({tag, "_rk1"}, dkey_o, rk1);
    for (int k = 1; k <= 9; k++) begin
      chk({tag, "_busy"}, 128'({busy_o, dkey_v_o}), 128'(2'b10));
      tick;
    end
    chk({tag, "_done"}, 128'({busy_o, dkey_v_o}), 128'(2'b01));
    chk({tag, "_dkey"}, dkey_o, dk);
    tick;
    chk({tag, "_after"}, 128'({busy_o, dkey_v_o}), 128'(2'b00));
    chk({tag, "_hold"}, dkey_o, dk);
  endtask

  initial begin
    reset   = 1'b1;
    key_v_i = 1'b0;
    key_i   = '0;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_flags", 128'({busy_o, dkey_v_o}), 128'(2'b00));
    chk("rst_dkey", dkey_o, '0);

    // Basic expansion of both FIPS-197 keys.
    request(KA);
    expect_full("a", RK1_A, DK_A);
    request(KB);
    expect_full("b", RK1_B, DK_B);

    // Request while busy is dropped.
    request(KA);
    for (int k = 1; k <= 9; k++) begin
      chk("ign_busy", 128'({busy_o, dkey_v_o}), 128'(2'b10));
      if (k == 4) begin
        key_v_i = 1'b1;
        key_i   = KB;
      end
      tick;
      key_v_i = 1'b0;
    end
    chk("ign_done", 128'({busy_o, dkey_v_o}), 128'(2'b01));
    chk("ign_dkey", dkey_o, DK_A);
    tick;
    chk("ign_after", 128'({busy_o, dkey_v_o}), 128'(2'b00));

    // Back-to-back: new request in the DONE cycle.
    request(KB);
    for (int k = 1; k <= 9; k++) begin
      chk("b2b_busy1", 128'({busy_o, dkey_v_o}), 128'(2'b10));
      tick;
    end
    chk("b2b_done1", 128'({busy_o, dkey_v_o}), 128'(2'b01));
    chk("b2b_dkey1", dkey_o, DK_B);
    request(KA);
    expect_full("b2b2", RK1_A, DK_A);

    // Reset in the middle of an expansion.
    request(KB);
    for (int k = 1; k <= 4; k++) begin
      chk("mid_busy", 128'({busy_o, dkey_v_o}), 128'(2'b10));
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_dkey", dkey_o, '0);
    for (int k = 6; k <= 13; k++) begin
      chk("mid_quiet", 128'({busy_o, dkey_v_o}), 128'(2'b00));
      tick;
    end
    request(KA);
    expect_full("post_rst", RK1_A, DK_A);

    // Repeat of the last completed key.
    request(KA);
`ifdef AES_DKEY_CACHE_EN
    chk("hit_done", 128'({busy_o, dkey_v_o}), 128'(2'b01));
    chk("hit_dkey", dkey_o, DK_A);
    tick;
    chk("hit_after", 128'({busy_o, dkey_v_o}), 128'(2'b00));
`else
    expect_full("rep", RK1_A, DK_A);
`endif
    request(KB);
    expect_full("miss", RK1_B, DK_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
